// File: rtl/trace_capture_buffer.sv
// On-chip circular trace recorder for the pipelined MIPS datapath. It captures
// {cycle, stall, rs, rd, pc, result} samples and supports a PC trigger and readback.
module trace_capture_buffer #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int REG_W     = 5,
    parameter int DEPTH     = 16,
    parameter int CYCLE_W   = 16,
    parameter int POST_TRIG = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int ENT_W = CYCLE_W + 1 + 2*REG_W + PC_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic              stall,
    input  logic [PC_W-1:0]   pc,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] result,
    input  logic              rd_req,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_valid,
    output logic [ENT_W-1:0]  rd_data,
    output logic [AW:0]       count,
    output logic              wrapped,
    output logic              triggered,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    typedef struct packed {
        logic [CYCLE_W-1:0] cyc;
        logic               stall;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rd;
        logic [PC_W-1:0]    pc;
        logic [DATA_W-1:0]  result;
    } entry_t;

    state_t             state, state_nx;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [CYCLE_W-1:0] cyc_cnt;
    logic [PC_W-1:0]    last_pc;
    logic [AW:0]        post_cnt;
    logic               qual, trig_hit, start, rd_ok;
    logic [AW-1:0]      rd_idx;
    entry_t             ent;

    assign busy  = (state == ARMED) || (state == POST);
    assign done  = (state == DONE);
    assign start = arm && (state == IDLE || state == DONE);

    always_comb begin
        qual = 1'b0;
        case (mode)
            2'd1:    qual = !stall;
            2'd2:    qual = (pc != last_pc);
            default: qual = 1'b1;
        endcase
        qual = qual && busy && !abort;
    end

    assign trig_hit = (state == ARMED) && qual && (pc == trig_pc) && (mode != 2'd3);

    // Address 0 maps to the oldest live entry; when full, that is wr_ptr itself.
    assign rd_idx = wr_ptr - count[AW-1:0] + rd_addr;
    assign rd_ok  = rd_req && !busy && !arm && !abort && ({1'b0, rd_addr} < count);

    assign ent = '{cyc: cyc_cnt, stall: stall, rs: rs, rd: rd, pc: pc, result: result};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (arm) state_nx = ARMED;
                ARMED: if (trig_hit) state_nx = (POST_TRIG == 1) ? DONE : POST;
                POST:  if (qual && post_cnt == (AW+1)'(1)) state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Trace storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && qual) mem[wr_ptr] <= ent;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
            wr_ptr    <= '0;
            cyc_cnt   <= '0;
            last_pc   <= '0;
            post_cnt  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= mem[rd_idx];
            if (abort) begin
                // contents, count and flags are frozen
            end else if (start) begin
                count     <= '0;
                wrapped   <= 1'b0;
                triggered <= 1'b0;
                wr_ptr    <= '0;
                cyc_cnt   <= '0;
                last_pc   <= ~pc;
            end else if (busy) begin
                cyc_cnt <= cyc_cnt + 1'b1;
                if (qual) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (count == (AW+1)'(DEPTH)) wrapped <= 1'b1;
                    else                         count   <= count + 1'b1;
                    if (mode == 2'd2) last_pc <= pc;
                end
                if (trig_hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= (AW+1)'(POST_TRIG - 1);
                end else if (state == POST && qual) begin
                    post_cnt <= post_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: capture modes, trigger/post window,
// wrap, readback ordering and reset during capture.
module tb_trace_capture_buffer;
    localparam int DATA_W = 32, PC_W = 32, REG_W = 5, DEPTH = 16, CYCLE_W = 16, POST_TRIG = 4;
    localparam int AW = $clog2(DEPTH);
    localparam int ENT_W = CYCLE_W + 1 + 2*REG_W + PC_W + DATA_W;

    logic clk = 0, rst_n = 0, arm = 0, abort = 0, stall = 0, rd_req = 0;
    logic [1:0] mode = 0;
    logic [PC_W-1:0] trig_pc = '1, pc = 0;
    logic [REG_W-1:0] rs = 0, rd = 0;
    logic [DATA_W-1:0] result = 0;
    logic [AW-1:0] rd_addr = 0;
    logic rd_valid, wrapped, triggered, busy, done;
    logic [ENT_W-1:0] rd_data;
    logic [AW:0] count;

    int total = 0, bad = 0;

    trace_capture_buffer #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_W(REG_W), .DEPTH(DEPTH),
                           .CYCLE_W(CYCLE_W), .POST_TRIG(POST_TRIG)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .mode(mode), .trig_pc(trig_pc),
        .stall(stall), .pc(pc), .rs(rs), .rd(rd), .result(result), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .count(count),
        .wrapped(wrapped), .triggered(triggered), .busy(busy), .done(done));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [PC_W-1:0] p, input logic s);
        pc = p; stall = s; rs = p[6:2]; rd = p[6:2] ^ 5'h1F; result = p ^ 32'hA5A5_0000;
        tick();
    endtask

    task automatic start(input logic [1:0] m, input logic [PC_W-1:0] t);
        mode = m; trig_pc = t; arm = 1; tick(); arm = 0;
    endtask

    task automatic stop();
        abort = 1; tick(); abort = 0;
    endtask

    task automatic rdback(input int a, output logic v, output logic [ENT_W-1:0] d);
        rd_req = 1; rd_addr = AW'(a); tick(); rd_req = 0;
        v = rd_valid; d = rd_data;
    endtask

    function automatic logic [PC_W-1:0] f_pc(input logic [ENT_W-1:0] d);
        return d[DATA_W +: PC_W];
    endfunction
    function automatic logic [CYCLE_W-1:0] f_cyc(input logic [ENT_W-1:0] d);
        return d[ENT_W-1 -: CYCLE_W];
    endfunction
    function automatic logic f_stall(input logic [ENT_W-1:0] d);
        return d[DATA_W + PC_W + 2*REG_W];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v;
        logic [ENT_W-1:0] d;
        logic st_or;
        int n;
        logic [PC_W-1:0] p5 [11];
        logic s5 [11];

        // reset state
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {wrapped, triggered, rd_valid}, 0);
        chk("rst_rd_data", rd_data[63:0], 0);
        rst_n = 1;

        // 1: mode0 three samples then abort, readback oldest first
        start(2'd0, 32'hFFFF_FFF0);
        chk("t1_busy", busy, 1);
        drive(0, 0); drive(4, 0); drive(8, 0);
        stop();
        chk("t1_busy_after_abort", busy, 0);
        chk("t1_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            rdback(i, v, d);
            chk($sformatf("t1_valid%0d", i), v, 1);
            chk($sformatf("t1_pc%0d", i), f_pc(d), 4*i);
            chk($sformatf("t1_cyc%0d", i), f_cyc(d), i);
        end
        chk("t1_result2", d[31:0], 32'hA5A5_0008);
        tick();
        chk("t1_valid_pulse", rd_valid, 0);
        rdback(3, v, d);
        chk("t1_oob_valid", v, 0);
        chk("t1_oob_hold", f_pc(d), 8);

        // 2: mode1, 22 busy cycles with stalls at stamps 3,4 -> 20 samples, wrap
        start(2'd1, 32'hFFFF_FFF0);
        for (int i = 0; i < 22; i++) drive(32'(4*i), (i == 3 || i == 4));
        stop();
        chk("t2_count", count, 16);
        chk("t2_wrapped", wrapped, 1);
        st_or = 0;
        for (int i = 0; i < 16; i++) begin
            rdback(i, v, d);
            st_or |= f_stall(d);
            if (i == 0) begin
                chk("t2_oldest_cyc", f_cyc(d), 6);
                chk("t2_oldest_pc", f_pc(d), 24);
            end
        end
        chk("t2_newest_cyc", f_cyc(d), 21);
        chk("t2_nostall", st_or, 0);

        // 3: mode2 only samples on pc change
        pc = 8;
        start(2'd2, 32'hFFFF_FFF0);
        drive(8, 0); drive(8, 0); drive(8, 0); drive(12, 0); drive(12, 0); drive(16, 0);
        stop();
        chk("t3_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            rdback(i, v, d);
            chk($sformatf("t3_pc%0d", i), f_pc(d), (i == 0) ? 8 : (i == 1) ? 12 : 16);
            chk($sformatf("t3_cyc%0d", i), f_cyc(d), (i == 0) ? 0 : (i == 1) ? 3 : 5);
        end

        // 4: mode0 trigger at 0x20 with three post samples
        start(2'd0, 32'h20);
        n = 0;
        while (!done && n < 40) begin
            drive(32'(4*n), 0);
            n++;
        end
        chk("t4_done", done, 1);
        chk("t4_last_pc", pc, 32'h2C);
        chk("t4_busy", busy, 0);
        chk("t4_triggered", triggered, 1);
        chk("t4_count", count, 12);
        chk("t4_wrapped", wrapped, 0);
        rdback(11, v, d);
        chk("t4_newest_pc", f_pc(d), 32'h2C);
        rdback(8, v, d);
        chk("t4_trig_pc", f_pc(d), 32'h20);

        // 5: arm beats rd_req in DONE; mode1 post window ignores stalls
        rd_req = 1; rd_addr = 0;
        start(2'd1, 32'h40);
        rd_req = 0;
        chk("t5_arm_wins_valid", rd_valid, 0);
        chk("t5_busy", busy, 1);
        chk("t5_cleared", {count, triggered}, 0);
        p5 = '{32'h40, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h44, 32'h48, 32'h48, 32'h48, 32'h4C, 32'h4C};
        s5 = '{1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0};
        for (int i = 0; i < 11; i++) begin
            drive(p5[i], s5[i]);
            if (i == 0) chk("t5_stalled_no_trig", triggered, 0);
            if (i == 9) chk("t5_busy_before_last", busy, 1);
        end
        chk("t5_done", done, 1);
        chk("t5_count", count, 6);
        rdback(5, v, d);
        chk("t5_newest_pc", f_pc(d), 32'h4C);
        chk("t5_newest_cyc", f_cyc(d), 10);
        rdback(2, v, d);
        chk("t5_trig_cyc", f_cyc(d), 3);

        // 6: arm ignored while busy, reset during POST, restart in mode3
        start(2'd0, 32'h10);
        drive(32'h0C, 0); drive(32'h10, 0);
        arm = 1; drive(32'h14, 0); arm = 0;
        chk("t6_arm_ignored", count, 3);
        chk("t6_in_post", {busy, triggered}, 2'b11);
        rst_n = 0; tick(); rst_n = 1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_state", {count, triggered, done}, 0);
        rdback(0, v, d);
        chk("t6_rst_rd_valid", v, 0);
        start(2'd3, 32'h100);
        drive(32'h100, 0); drive(32'h104, 0); drive(32'h100, 0);
        chk("t6_mode3_no_trig", {busy, triggered}, 2'b10);
        stop();
        chk("t6_count", count, 3);
        rdback(0, v, d);
        chk("t6_restart_cyc", f_cyc(d), 0);
        chk("t6_restart_pc", f_pc(d), 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
